// File: rtl/rx_payload_consumer.sv
// rx_payload_consumer: application-side reader of the per-flow RX payload ring.
// For each app read request it fetches the flow's commit and tail pointers,
// grants min(request, readable bytes), advances the tail by the grant and
// returns the ring offset and granted length. One request in flight at a time.
module rx_payload_consumer #(
  parameter int flowid_w_p = 8,
  parameter int ptr_w_p    = 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  app_rd_req_val,
  input  logic [flowid_w_p-1:0] app_rd_req_flowid,
  input  logic [ptr_w_p:0]      app_rd_req_len,
  output logic                  app_rd_req_rdy,

  output logic                  app_rd_resp_val,
  output logic [flowid_w_p-1:0] app_rd_resp_flowid,
  output logic [ptr_w_p-1:0]    app_rd_resp_addr,
  output logic [ptr_w_p:0]      app_rd_resp_len,
  output logic                  app_rd_resp_err,
  input  logic                  app_rd_resp_rdy,

  output logic                  commit_ptr_rd_req_val,
  output logic [flowid_w_p-1:0] commit_ptr_rd_req_addr,
  input  logic                  commit_ptr_rd_req_rdy,
  input  logic                  commit_ptr_rd_resp_val,
  input  logic [ptr_w_p:0]      commit_ptr_rd_resp_data,
  output logic                  commit_ptr_rd_resp_rdy,

  output logic                  tail_ptr_rd_req_val,
  output logic [flowid_w_p-1:0] tail_ptr_rd_req_addr,
  input  logic                  tail_ptr_rd_req_rdy,
  input  logic                  tail_ptr_rd_resp_val,
  input  logic [ptr_w_p:0]      tail_ptr_rd_resp_data,
  output logic                  tail_ptr_rd_resp_rdy,

  output logic                  tail_ptr_wr_req_val,
  output logic [flowid_w_p-1:0] tail_ptr_wr_req_addr,
  output logic [ptr_w_p:0]      tail_ptr_wr_req_data,
  input  logic                  tail_ptr_wr_req_rdy
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_RESP,
    CALC,
    WR_TAIL,
    RESP
  } state_t;

  // A completely full ring holds exactly 2^ptr_w_p bytes.
  localparam logic [ptr_w_p:0] RING_BYTES = {1'b1, {ptr_w_p{1'b0}}};

  state_t                r_state;
  logic [flowid_w_p-1:0] r_flowid;
  logic [ptr_w_p:0]      r_len;
  logic                  r_commit_sent;
  logic                  r_tail_sent;
  logic                  r_commit_got;
  logic                  r_tail_got;
  logic [ptr_w_p:0]      r_commit_ptr;
  logic [ptr_w_p:0]      r_tail_ptr;
  logic                  r_commit_req_val;
  logic                  r_tail_req_val;
  logic                  r_commit_resp_rdy;
  logic                  r_tail_resp_rdy;
  logic                  r_wr_val;
  logic [ptr_w_p:0]      r_wr_data;
  logic                  r_resp_val;
  logic [ptr_w_p-1:0]    r_resp_addr;
  logic [ptr_w_p:0]      r_resp_len;
  logic                  r_resp_err;

  logic                  w_app_req_fire;
  logic                  w_commit_req_fire;
  logic                  w_tail_req_fire;
  logic                  w_commit_resp_fire;
  logic                  w_tail_resp_fire;
  logic                  w_both_sent;
  logic                  w_both_got;
  logic [ptr_w_p:0]      w_avail;
  logic                  w_err;
  logic [ptr_w_p:0]      w_grant;
  logic [ptr_w_p:0]      w_new_tail;

  // Handshake strobes; the "both" terms include a flag being set this cycle so
  // the common case does not lose a cycle waiting for the flag register.
  assign w_app_req_fire     = app_rd_req_val && app_rd_req_rdy;
  assign w_commit_req_fire  = r_commit_req_val && commit_ptr_rd_req_rdy;
  assign w_tail_req_fire    = r_tail_req_val && tail_ptr_rd_req_rdy;
  assign w_commit_resp_fire = r_commit_resp_rdy && commit_ptr_rd_resp_val;
  assign w_tail_resp_fire   = r_tail_resp_rdy && tail_ptr_rd_resp_val;
  assign w_both_sent        = (r_commit_sent || w_commit_req_fire) && (r_tail_sent || w_tail_req_fire);
  assign w_both_got         = (r_commit_got || w_commit_resp_fire) && (r_tail_got || w_tail_resp_fire);

  // Readable bytes and grant; the pointer difference is modulo the wrap-bit width,
  // so anything beyond a full ring can only come from a corrupted pointer pair.
  assign w_avail    = r_commit_ptr - r_tail_ptr;
  assign w_err      = (w_avail > RING_BYTES);
  assign w_grant    = w_err ? '0 : ((r_len < w_avail) ? r_len : w_avail);
  assign w_new_tail = r_tail_ptr + w_grant;

  // Request ready must read low while rst is held and high the first cycle after.
  assign app_rd_req_rdy = (r_state == IDLE) && !rst;

  assign commit_ptr_rd_req_val  = r_commit_req_val;
  assign commit_ptr_rd_req_addr = r_flowid;
  assign commit_ptr_rd_resp_rdy = r_commit_resp_rdy;
  assign tail_ptr_rd_req_val    = r_tail_req_val;
  assign tail_ptr_rd_req_addr   = r_flowid;
  assign tail_ptr_rd_resp_rdy   = r_tail_resp_rdy;
  assign tail_ptr_wr_req_val    = r_wr_val;
  assign tail_ptr_wr_req_addr   = r_flowid;
  assign tail_ptr_wr_req_data   = r_wr_data;
  assign app_rd_resp_val        = r_resp_val;
  assign app_rd_resp_flowid     = r_flowid;
  assign app_rd_resp_addr       = r_resp_addr;
  assign app_rd_resp_len        = r_resp_len;
  assign app_rd_resp_err        = r_resp_err;

  // Request sequencer: pointer fetch, grant computation, tail update, response.
  always_ff @(posedge clk) begin
    // NOTE: every state register uses <= so all updates see pre-edge values;
    // the later case statement may override the common handshake updates.
    if (rst) begin
      r_state           <= IDLE;
      r_flowid          <= '0;
      r_len             <= '0;
      r_commit_sent     <= 1'b0;
      r_tail_sent       <= 1'b0;
      r_commit_got      <= 1'b0;
      r_tail_got        <= 1'b0;
      r_commit_ptr      <= '0;
      r_tail_ptr        <= '0;
      r_commit_req_val  <= 1'b0;
      r_tail_req_val    <= 1'b0;
      r_commit_resp_rdy <= 1'b0;
      r_tail_resp_rdy   <= 1'b0;
      r_wr_val          <= 1'b0;
      r_wr_data         <= '0;
      r_resp_val        <= 1'b0;
      r_resp_addr       <= '0;
      r_resp_len        <= '0;
      r_resp_err        <= 1'b0;
    end else begin
      // Per-port read handshakes, independent of each other and of the state.
      if (w_commit_req_fire) begin
        r_commit_sent    <= 1'b1;
        r_commit_req_val <= 1'b0;
      end
      if (w_tail_req_fire) begin
        r_tail_sent    <= 1'b1;
        r_tail_req_val <= 1'b0;
      end
      if (w_commit_resp_fire) begin
        r_commit_ptr      <= commit_ptr_rd_resp_data;
        r_commit_got      <= 1'b1;
        r_commit_resp_rdy <= 1'b0;
      end
      if (w_tail_resp_fire) begin
        r_tail_ptr      <= tail_ptr_rd_resp_data;
        r_tail_got      <= 1'b1;
        r_tail_resp_rdy <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_app_req_fire) begin
            r_flowid          <= app_rd_req_flowid;
            r_len             <= app_rd_req_len;
            r_commit_sent     <= 1'b0;
            r_tail_sent       <= 1'b0;
            r_commit_got      <= 1'b0;
            r_tail_got        <= 1'b0;
            r_commit_req_val  <= 1'b1;
            r_tail_req_val    <= 1'b1;
            r_commit_resp_rdy <= 1'b1;
            r_tail_resp_rdy   <= 1'b1;
            r_state           <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (w_both_sent) begin
            r_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (w_both_got) begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_resp_addr <= r_tail_ptr[ptr_w_p-1:0];
          r_resp_len  <= w_grant;
          r_resp_err  <= w_err;
          r_wr_data   <= w_new_tail;
          if (w_grant != '0) begin
            r_wr_val <= 1'b1;
            r_state  <= WR_TAIL;
          end else begin
            r_resp_val <= 1'b1;
            r_state    <= RESP;
          end
        end
        WR_TAIL: begin
          if (tail_ptr_wr_req_rdy) begin
            r_wr_val   <= 1'b0;
            r_resp_val <= 1'b1;
            r_state    <= RESP;
          end
        end
        RESP: begin
          if (app_rd_resp_rdy) begin
            r_resp_val <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_payload_consumer.sv
// Bench for rx_payload_consumer: models the RX payload pointer store (1-cycle
// read latency, per-port stall knobs) and checks each app read against a
// ring-arithmetic reference computed from the stored pointers.
module tb_rx_payload_consumer;

  localparam int FW   = 4;
  localparam int PW   = 8;
  localparam int MODV = 512;
  localparam int RING = 256;

  logic          clk = 1'b0;
  logic          rst;

  logic          app_rd_req_val;
  logic [FW-1:0] app_rd_req_flowid;
  logic [PW:0]   app_rd_req_len;
  logic          app_rd_req_rdy;
  logic          app_rd_resp_val;
  logic [FW-1:0] app_rd_resp_flowid;
  logic [PW-1:0] app_rd_resp_addr;
  logic [PW:0]   app_rd_resp_len;
  logic          app_rd_resp_err;
  logic          app_rd_resp_rdy;
  logic          commit_ptr_rd_req_val;
  logic [FW-1:0] commit_ptr_rd_req_addr;
  logic          commit_ptr_rd_req_rdy;
  logic          commit_ptr_rd_resp_val;
  logic [PW:0]   commit_ptr_rd_resp_data;
  logic          commit_ptr_rd_resp_rdy;
  logic          tail_ptr_rd_req_val;
  logic [FW-1:0] tail_ptr_rd_req_addr;
  logic          tail_ptr_rd_req_rdy;
  logic          tail_ptr_rd_resp_val;
  logic [PW:0]   tail_ptr_rd_resp_data;
  logic          tail_ptr_rd_resp_rdy;
  logic          tail_ptr_wr_req_val;
  logic [FW-1:0] tail_ptr_wr_req_addr;
  logic [PW:0]   tail_ptr_wr_req_data;
  logic          tail_ptr_wr_req_rdy;

  always #5 clk = ~clk;

  rx_payload_consumer #(.flowid_w_p(FW), .ptr_w_p(PW)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .app_rd_req_val          (app_rd_req_val),
    .app_rd_req_flowid       (app_rd_req_flowid),
    .app_rd_req_len          (app_rd_req_len),
    .app_rd_req_rdy          (app_rd_req_rdy),
    .app_rd_resp_val         (app_rd_resp_val),
    .app_rd_resp_flowid      (app_rd_resp_flowid),
    .app_rd_resp_addr        (app_rd_resp_addr),
    .app_rd_resp_len         (app_rd_resp_len),
    .app_rd_resp_err         (app_rd_resp_err),
    .app_rd_resp_rdy         (app_rd_resp_rdy),
    .commit_ptr_rd_req_val   (commit_ptr_rd_req_val),
    .commit_ptr_rd_req_addr  (commit_ptr_rd_req_addr),
    .commit_ptr_rd_req_rdy   (commit_ptr_rd_req_rdy),
    .commit_ptr_rd_resp_val  (commit_ptr_rd_resp_val),
    .commit_ptr_rd_resp_data (commit_ptr_rd_resp_data),
    .commit_ptr_rd_resp_rdy  (commit_ptr_rd_resp_rdy),
    .tail_ptr_rd_req_val     (tail_ptr_rd_req_val),
    .tail_ptr_rd_req_addr    (tail_ptr_rd_req_addr),
    .tail_ptr_rd_req_rdy     (tail_ptr_rd_req_rdy),
    .tail_ptr_rd_resp_val    (tail_ptr_rd_resp_val),
    .tail_ptr_rd_resp_data   (tail_ptr_rd_resp_data),
    .tail_ptr_rd_resp_rdy    (tail_ptr_rd_resp_rdy),
    .tail_ptr_wr_req_val     (tail_ptr_wr_req_val),
    .tail_ptr_wr_req_addr    (tail_ptr_wr_req_addr),
    .tail_ptr_wr_req_data    (tail_ptr_wr_req_data),
    .tail_ptr_wr_req_rdy     (tail_ptr_wr_req_rdy)
  );

  // Pointer store contents (written by observed tail writes).
  int commit_mem [16];
  int tail_mem   [16];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Per-transaction observations.
  int wr_cnt, wr_val_cycles, crd_cnt, trd_cnt;
  int last_wr_addr, last_wr_data;
  int req_cyc, resp_cyc;
  bit req_seen, resp_seen;
  int got_flowid, got_addr, got_len, got_err;

  // Stall knobs: cycles a ready is held low while the matching val is high.
  int crd_stall, trd_stall, wr_stall, resp_stall;

  // Stall-stability tracking.
  bit p_trd_st, p_crd_st, p_wr_st, p_resp_st;
  int p_trd_addr, p_crd_addr, p_wr_addr, p_wr_data;
  int p_resp_f, p_resp_a, p_resp_l, p_resp_e;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive readies, predict handshakes at the coming edge,
  // then advance the pointer-store model just after the edge.
  task automatic cycle();
    bit r, f_app, f_crq, f_trq, f_crs, f_trs, f_wr, f_resp;
    int a_crq, a_trq, a_wr, d_wr;
    #1;
    commit_ptr_rd_req_rdy = !(commit_ptr_rd_req_val && crd_stall > 0);
    if (commit_ptr_rd_req_val && crd_stall > 0) crd_stall--;
    tail_ptr_rd_req_rdy = !(tail_ptr_rd_req_val && trd_stall > 0);
    if (tail_ptr_rd_req_val && trd_stall > 0) trd_stall--;
    tail_ptr_wr_req_rdy = !(tail_ptr_wr_req_val && wr_stall > 0);
    if (tail_ptr_wr_req_val && wr_stall > 0) wr_stall--;
    app_rd_resp_rdy = !(app_rd_resp_val && resp_stall > 0);
    if (app_rd_resp_val && resp_stall > 0) resp_stall--;

    if (p_crd_st) begin
      check("crd_hold_val", int'(commit_ptr_rd_req_val), 1);
      check("crd_hold_addr", int'(commit_ptr_rd_req_addr), p_crd_addr);
    end
    if (p_trd_st) begin
      check("trd_hold_val", int'(tail_ptr_rd_req_val), 1);
      check("trd_hold_addr", int'(tail_ptr_rd_req_addr), p_trd_addr);
    end
    if (p_wr_st) begin
      check("wr_hold_val", int'(tail_ptr_wr_req_val), 1);
      check("wr_hold_addr", int'(tail_ptr_wr_req_addr), p_wr_addr);
      check("wr_hold_data", int'(tail_ptr_wr_req_data), p_wr_data);
    end
    if (p_resp_st) begin
      check("resp_hold_val", int'(app_rd_resp_val), 1);
      check("resp_hold_flowid", int'(app_rd_resp_flowid), p_resp_f);
      check("resp_hold_addr", int'(app_rd_resp_addr), p_resp_a);
      check("resp_hold_len", int'(app_rd_resp_len), p_resp_l);
      check("resp_hold_err", int'(app_rd_resp_err), p_resp_e);
    end

    r = rst;
    p_crd_st   = commit_ptr_rd_req_val && !commit_ptr_rd_req_rdy && !r;
    p_crd_addr = int'(commit_ptr_rd_req_addr);
    p_trd_st   = tail_ptr_rd_req_val && !tail_ptr_rd_req_rdy && !r;
    p_trd_addr = int'(tail_ptr_rd_req_addr);
    p_wr_st    = tail_ptr_wr_req_val && !tail_ptr_wr_req_rdy && !r;
    p_wr_addr  = int'(tail_ptr_wr_req_addr);
    p_wr_data  = int'(tail_ptr_wr_req_data);
    p_resp_st  = app_rd_resp_val && !app_rd_resp_rdy && !r;
    p_resp_f   = int'(app_rd_resp_flowid);
    p_resp_a   = int'(app_rd_resp_addr);
    p_resp_l   = int'(app_rd_resp_len);
    p_resp_e   = int'(app_rd_resp_err);

    f_app  = app_rd_req_val && app_rd_req_rdy && !r;
    f_crq  = commit_ptr_rd_req_val && commit_ptr_rd_req_rdy && !r;
    f_trq  = tail_ptr_rd_req_val && tail_ptr_rd_req_rdy && !r;
    f_crs  = commit_ptr_rd_resp_val && commit_ptr_rd_resp_rdy && !r;
    f_trs  = tail_ptr_rd_resp_val && tail_ptr_rd_resp_rdy && !r;
    f_wr   = tail_ptr_wr_req_val && tail_ptr_wr_req_rdy && !r;
    f_resp = app_rd_resp_val && app_rd_resp_rdy && !r;
    a_crq  = int'(commit_ptr_rd_req_addr);
    a_trq  = int'(tail_ptr_rd_req_addr);
    a_wr   = int'(tail_ptr_wr_req_addr);
    d_wr   = int'(tail_ptr_wr_req_data);
    if (tail_ptr_wr_req_val && !r) wr_val_cycles++;
    if (f_resp) begin
      got_flowid = int'(app_rd_resp_flowid);
      got_addr   = int'(app_rd_resp_addr);
      got_len    = int'(app_rd_resp_len);
      got_err    = int'(app_rd_resp_err);
    end

    @(posedge clk);
    #1;
    cyc++;
    if (f_crs) commit_ptr_rd_resp_val = 1'b0;
    if (f_trs) tail_ptr_rd_resp_val = 1'b0;
    if (f_crq) begin
      commit_ptr_rd_resp_val  = 1'b1;
      commit_ptr_rd_resp_data = (PW+1)'(commit_mem[a_crq]);
      crd_cnt++;
    end
    if (f_trq) begin
      tail_ptr_rd_resp_val  = 1'b1;
      tail_ptr_rd_resp_data = (PW+1)'(tail_mem[a_trq]);
      trd_cnt++;
    end
    if (r) begin
      commit_ptr_rd_resp_val = 1'b0;
      tail_ptr_rd_resp_val   = 1'b0;
    end
    if (f_wr) begin
      tail_mem[a_wr] = d_wr;
      wr_cnt++;
      last_wr_addr = a_wr;
      last_wr_data = d_wr;
    end
    if (f_app) begin
      req_seen       = 1'b1;
      req_cyc        = cyc;
      app_rd_req_val = 1'b0;
    end
    if (f_resp) begin
      resp_seen = 1'b1;
      resp_cyc  = cyc;
    end
  endtask

  task automatic clear_obs();
    wr_cnt = 0; wr_val_cycles = 0; crd_cnt = 0; trd_cnt = 0;
    last_wr_addr = -1; last_wr_data = -1;
    req_seen = 1'b0; resp_seen = 1'b0; req_cyc = 0; resp_cyc = 0;
    got_flowid = -1; got_addr = -1; got_len = -1; got_err = -1;
  endtask

  // Issue one read and check it against ring arithmetic on the stored pointers.
  // exp_lat_on: also check the request-to-response cycle distance (no stalls).
  task automatic run_txn(input string tag, input int flow, input int len, input bit exp_lat_on);
    int t, c, avail, err, grant, new_tail;
    t        = tail_mem[flow];
    c        = commit_mem[flow];
    avail    = (c - t + MODV) % MODV;
    err      = (avail > RING) ? 1 : 0;
    grant    = err ? 0 : ((len < avail) ? len : avail);
    new_tail = (t + grant) % MODV;

    clear_obs();
    app_rd_req_val    = 1'b1;
    app_rd_req_flowid = FW'(flow);
    app_rd_req_len    = (PW+1)'(len);
    for (int i = 0; i < 200 && !resp_seen; i++) cycle();

    check({tag, "_resp_seen"}, int'(resp_seen), 1);
    check({tag, "_flowid"}, got_flowid, flow);
    check({tag, "_addr"}, got_addr, t % RING);
    check({tag, "_len"}, got_len, grant);
    check({tag, "_err"}, got_err, err);
    check({tag, "_commit_reads"}, crd_cnt, 1);
    check({tag, "_tail_reads"}, trd_cnt, 1);
    check({tag, "_tail_writes"}, wr_cnt, (grant != 0) ? 1 : 0);
    if (grant != 0) begin
      check({tag, "_wr_addr"}, last_wr_addr, flow);
      check({tag, "_wr_data"}, last_wr_data, new_tail);
    end else begin
      check({tag, "_wr_val_cycles"}, wr_val_cycles, 0);
    end
    check({tag, "_stored_tail"}, tail_mem[flow], new_tail);
    if (exp_lat_on) check({tag, "_latency"}, resp_cyc - req_cyc, (grant != 0) ? 5 : 4);
    check({tag, "_req_rdy_after"}, int'(app_rd_req_rdy), 1);
  endtask

  task automatic set_flow(input int flow, input int tail, input int commit);
    tail_mem[flow]   = tail;
    commit_mem[flow] = commit;
  endtask

  initial begin
    int f, t, sel, avail, len;
    bit quiet;

    rst                     = 1'b1;
    app_rd_req_val          = 1'b0;
    app_rd_req_flowid       = '0;
    app_rd_req_len          = '0;
    app_rd_resp_rdy         = 1'b1;
    commit_ptr_rd_req_rdy   = 1'b1;
    commit_ptr_rd_resp_val  = 1'b0;
    commit_ptr_rd_resp_data = '0;
    tail_ptr_rd_req_rdy     = 1'b1;
    tail_ptr_rd_resp_val    = 1'b0;
    tail_ptr_rd_resp_data   = '0;
    tail_ptr_wr_req_rdy     = 1'b1;
    crd_stall = 0; trd_stall = 0; wr_stall = 0; resp_stall = 0;
    p_crd_st = 0; p_trd_st = 0; p_wr_st = 0; p_resp_st = 0;
    for (int i = 0; i < 16; i++) set_flow(i, 0, 0);
    clear_obs();

    // Reset state.
    repeat (3) cycle();
    check("rst_req_rdy", int'(app_rd_req_rdy), 0);
    check("rst_commit_rd_val", int'(commit_ptr_rd_req_val), 0);
    check("rst_tail_rd_val", int'(tail_ptr_rd_req_val), 0);
    check("rst_tail_wr_val", int'(tail_ptr_wr_req_val), 0);
    check("rst_resp_val", int'(app_rd_resp_val), 0);
    check("rst_commit_resp_rdy", int'(commit_ptr_rd_resp_rdy), 0);
    check("rst_tail_resp_rdy", int'(tail_ptr_rd_resp_rdy), 0);
    check("rst_resp_len", int'(app_rd_resp_len), 0);
    check("rst_resp_addr", int'(app_rd_resp_addr), 0);
    check("rst_wr_data", int'(tail_ptr_wr_req_data), 0);
    rst = 1'b0;
    #1;
    check("rst_release_req_rdy", int'(app_rd_req_rdy), 1);

    // Directed scenarios.
    set_flow(3, 'h010, 'h050);
    run_txn("basic", 3, 'h20, 1'b1);
    set_flow(7, 'h0F0, 'h110);
    run_txn("wrap", 7, 'h40, 1'b1);
    set_flow(9, 'h1A0, 'h1A0);
    run_txn("empty", 9, 'h10, 1'b1);
    set_flow(2, 'h000, 'h180);
    run_txn("corrupt", 2, 'h20, 1'b1);
    set_flow(4, 'h0C0, 'h1C0);
    run_txn("full", 4, 'h1FF, 1'b1);
    set_flow(6, 'h020, 'h060);
    run_txn("zero_len", 6, 0, 1'b1);

    // Backpressure on tail read, tail write and app response.
    set_flow(3, 'h010, 'h050);
    trd_stall = 3; wr_stall = 2; resp_stall = 4;
    run_txn("stall", 3, 'h20, 1'b0);
    trd_stall = 0; wr_stall = 0; resp_stall = 0;

    // Reset while the tail write is stalled.
    set_flow(5, 'h010, 'h050);
    clear_obs();
    wr_stall          = 100;
    app_rd_req_val    = 1'b1;
    app_rd_req_flowid = FW'(5);
    app_rd_req_len    = (PW+1)'('h20);
    for (int i = 0; i < 30 && !tail_ptr_wr_req_val; i++) cycle();
    check("midrst_reached_wr", int'(tail_ptr_wr_req_val), 1);
    rst = 1'b1;
    cycle();
    check("midrst_wr_val", int'(tail_ptr_wr_req_val), 0);
    check("midrst_resp_val", int'(app_rd_resp_val), 0);
    check("midrst_commit_rd_val", int'(commit_ptr_rd_req_val), 0);
    check("midrst_tail_rd_val", int'(tail_ptr_rd_req_val), 0);
    check("midrst_req_rdy_in_rst", int'(app_rd_req_rdy), 0);
    rst      = 1'b0;
    wr_stall = 0;
    #1;
    check("midrst_req_rdy_after", int'(app_rd_req_rdy), 1);
    check("midrst_no_write", wr_cnt, 0);
    check("midrst_tail_kept", tail_mem[5], 'h010);
    run_txn("post_rst", 5, 'h20, 1'b1);

    // Randomized reads against the ring-arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      f   = $urandom_range(0, 15);
      t   = $urandom_range(0, MODV - 1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      avail = 0;
      else if (sel == 1) avail = RING;
      else if (sel == 2) avail = $urandom_range(RING + 1, MODV - 1);
      else               avail = $urandom_range(1, RING - 1);
      set_flow(f, t, (t + avail) % MODV);
      len   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MODV - 1);
      quiet = ($urandom_range(0, 2) == 0);
      crd_stall  = quiet ? 0 : $urandom_range(0, 3);
      trd_stall  = quiet ? 0 : $urandom_range(0, 3);
      wr_stall   = quiet ? 0 : $urandom_range(0, 3);
      resp_stall = quiet ? 0 : $urandom_range(0, 3);
      run_txn("rand", f, len, quiet);
      crd_stall = 0; trd_stall = 0; wr_stall = 0; resp_stall = 0;
      repeat ($urandom_range(0, 2)) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
